// File: rtl/frame_mux4.sv
// frame_mux4: 4:1 word time-multiplexer on the clock4x domain.
// Ports: clock4x, reset (sync, active-high), strobe, data_in[4*WIDTH],
//   data_out[WIDTH], phase[2], frame_start, valid_out, locked, strobe_err,
//   err_count[8] (only with FRAME_MUX4_ERRCNT_EN defined).
module frame_mux4 #(
  parameter int WIDTH      = 14,
  parameter int LOCK_COUNT = 8
) (
  input  logic               clock4x,
  input  logic               reset,
  input  logic               strobe,
  input  logic [4*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic [1:0]         phase,
  output logic               frame_start,
  output logic               valid_out,
  output logic               locked,
  output logic               strobe_err
`ifdef FRAME_MUX4_ERRCNT_EN
  ,
  output logic [7:0]         err_count
`endif
);

  localparam int CW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [1:0]         gap_q, gap_d;
  logic [4*WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [1:0]         ph_q, ph_d, ph_nx;
  logic               act_q, act_d;
  logic               fs_q, fs_d;
  logic               vld_q;
  logic               err_q, err_d;
  logic               adv, good, early, missing;

  assign ph_nx = ph_q + 2'd1;
  assign adv   = !strobe && act_q && (ph_q != 2'd3);

  always_comb begin
    dout_d = dout_q;
    ph_d   = ph_q;
    fs_d   = 1'b0;
    hold_d = hold_q;
    act_d  = act_q;
    unique case (1'b1)
      strobe: begin
        dout_d = data_in[WIDTH-1:0];
        hold_d = data_in;
        ph_d   = 2'd0;
        fs_d   = 1'b1;
        act_d  = 1'b1;
      end
      adv: begin
        dout_d = hold_q[int'(ph_nx)*WIDTH +: WIDTH];
        ph_d   = ph_nx;
      end
      default: ;
    endcase
  end

  // gap saturates at 3 so a long silence still reads as "due"
  always_comb begin
    gap_d = gap_q;
    if (strobe)
      gap_d = 2'd0;
    else if (gap_q != 2'd3)
      gap_d = gap_q + 2'd1;
  end

  assign good    = strobe && (gap_q == 2'd3);
  assign early   = strobe && (gap_q != 2'd3) &&
                   (state_q != UNLOCKED);
  assign missing = !strobe && (gap_q == 2'd3) &&
                   (state_q != UNLOCKED);
  assign err_d   = early || missing;

  assign cnt_inc = (cnt_q == CW'(LOCK_COUNT)) ?
                   cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UNLOCKED: begin
        if (strobe) begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end
      end
      ACQUIRE: begin
        if (good) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(LOCK_COUNT))
            state_d = LOCKED;
        end else if (early) begin
          cnt_d = '0;
        end else if (missing) begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (early) begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end else if (missing) begin
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
      gap_q   <= 2'd0;
      hold_q  <= '0;
      dout_q  <= '0;
      ph_q    <= 2'd0;
      act_q   <= 1'b0;
      fs_q    <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      ph_q    <= ph_d;
      act_q   <= act_d;
      fs_q    <= fs_d;
      vld_q   <= (state_d == LOCKED);
      err_q   <= err_d;
    end
  end

  assign data_out    = dout_q;
  assign phase       = ph_q;
  assign frame_start = fs_q;
  assign valid_out   = vld_q;
  assign locked      = (state_q == LOCKED);
  assign strobe_err  = err_q;

`ifdef FRAME_MUX4_ERRCNT_EN
  logic [7:0] ecnt_q;

  always_ff @(posedge clock4x) begin
    if (reset)
      ecnt_q <= 8'd0;
    else if (err_q && (ecnt_q != 8'hff))
      ecnt_q <= ecnt_q + 8'd1;
  end

  assign err_count = ecnt_q;
`endif

endmodule

// File: tb/tb_frame_mux4.sv
// tb_frame_mux4: directed bench for frame_mux4.
// Runs a default instance and a LOCK_COUNT=1, WIDTH=8 instance.
module tb_frame_mux4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic [55:0] din = '0;
  logic [13:0] dout;
  logic [1:0]  ph;
  logic        fs, vld, lk, err;

  logic        reset2 = 1'b1;
  logic        strobe2 = 1'b0;
  logic [31:0] din2 = '0;
  logic [7:0]  dout2;
  logic [1:0]  ph2;
  logic        fs2, vld2, lk2, err2;
`ifdef FRAME_MUX4_ERRCNT_EN
  logic [7:0]  ecnt, ecnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_mux4 dut (
    .clock4x(clk), .reset(reset),
    .strobe(strobe), .data_in(din),
    .data_out(dout), .phase(ph),
    .frame_start(fs), .valid_out(vld),
    .locked(lk), .strobe_err(err)
`ifdef FRAME_MUX4_ERRCNT_EN
    , .err_count(ecnt)
`endif
  );

  frame_mux4 #(.WIDTH(8), .LOCK_COUNT(1)) dut2 (
    .clock4x(clk), .reset(reset2),
    .strobe(strobe2), .data_in(din2),
    .data_out(dout2), .phase(ph2),
    .frame_start(fs2), .valid_out(vld2),
    .locked(lk2), .strobe_err(err2)
`ifdef FRAME_MUX4_ERRCNT_EN
    , .err_count(ecnt2)
`endif
  );

  typedef struct {
    logic        stb;
    logic [55:0] din;
    logic [13:0] dout;
    logic [1:0]  ph;
    logic        fs;
    logic        lk;
  } vec_t;

  vec_t tbl[40];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    strobe = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, a, e);
    end
  endtask

  function automatic logic [55:0] mkfr(input int b);
    logic [55:0] r;
    for (int k = 0; k < 4; k++)
      r[k*14 +: 14] = 14'(b + k);
    return r;
  endfunction

  logic [55:0] fr;
  logic [31:0] r2;

  initial begin
    for (int f = 0; f < 10; f++)
      for (int c = 0; c < 4; c++) begin
        tbl[f*4+c].stb  = (c == 0);
        tbl[f*4+c].din  = mkfr(f * 16);
        tbl[f*4+c].dout = 14'(f * 16 + c);
        tbl[f*4+c].ph   = 2'(c);
        tbl[f*4+c].fs   = (c == 0);
        tbl[f*4+c].lk   = (f >= 8);
      end

    step();
    step();
    chk("rst dout", dout, 0);
    chk("rst phase", ph, 0);
    chk("rst fs", fs, 0);
    chk("rst valid", vld, 0);
    chk("rst locked", lk, 0);
    chk("rst err", err, 0);
    reset  = 1'b0;
    reset2 = 1'b0;

    for (int i = 0; i < 40; i++) begin
      strobe = tbl[i].stb;
      din    = tbl[i].din;
      step();
      chk($sformatf("t%0d dout", i), dout, tbl[i].dout);
      chk($sformatf("t%0d ph", i), ph, tbl[i].ph);
      chk($sformatf("t%0d fs", i), fs, tbl[i].fs);
      chk($sformatf("t%0d lk", i), lk, tbl[i].lk);
      chk($sformatf("t%0d vld", i), vld, tbl[i].lk);
      chk($sformatf("t%0d err", i), err, 0);
    end

    // early strobe while locked (gap 2)
    strobe = 1'b1;
    din    = mkfr(14'h200);
    step();
    chk("A good lk", lk, 1);
    idle(2);
    strobe = 1'b1;
    din    = mkfr(14'h300);
    step();
    chk("A err", err, 1);
    chk("A lk", lk, 0);
    chk("A vld", vld, 0);
    chk("A dout", dout, 14'h300);
    chk("A fs", fs, 1);
    idle(1);
    chk("A err clr", err, 0);
    chk("A w1", dout, 14'h301);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      strobe = 1'b1;
      din    = mkfr(14'h400 + i * 4);
      step();
      chk($sformatf("A relk%0d", i), lk, (i == 7));
      chk($sformatf("A revld%0d", i), vld, (i == 7));
      chk($sformatf("A reerr%0d", i), err, 0);
      idle(3);
    end

    // omitted strobe while locked
    strobe = 1'b1;
    din    = mkfr(14'h500);
    step();
    idle(3);
    chk("B w3", dout, 14'h503);
    chk("B err0", err, 0);
    idle(1);
    chk("B err", err, 1);
    chk("B lk", lk, 0);
    chk("B vld", vld, 0);
    chk("B hold", dout, 14'h503);
    chk("B ph", ph, 3);
    idle(1);
    chk("B err clr", err, 0);
    chk("B hold2", dout, 14'h503);
    idle(2);
    strobe = 1'b1;
    din    = mkfr(14'h600);
    step();
    chk("B acq err", err, 0);
    chk("B acq dout", dout, 14'h600);
    chk("B acq lk", lk, 0);
    idle(3);
    chk("B acq e0", err, 0);
    idle(1);
    chk("B acq miss", err, 1);

    // reset coincident with strobe, mid-lock
    strobe = 1'b1;
    din    = mkfr(14'h700);
    step();
    for (int i = 0; i < 8; i++) begin
      idle(3);
      strobe = 1'b1;
      din    = mkfr(14'h710 + i * 4);
      step();
    end
    chk("C lk", lk, 1);
    idle(2);
    reset  = 1'b1;
    strobe = 1'b1;
    din    = mkfr(14'h800);
    step();
    chk("C dout", dout, 0);
    chk("C ph", ph, 0);
    chk("C fs", fs, 0);
    chk("C vld", vld, 0);
    chk("C lk", lk, 0);
    chk("C err", err, 0);
    reset = 1'b0;
    idle(5);
    chk("C quiet err", err, 0);
    chk("C quiet dout", dout, 0);
    strobe = 1'b1;
    din    = mkfr(14'h900);
    step();
    chk("C acq dout", dout, 14'h900);
    chk("C acq err", err, 0);
    idle(3);
    chk("C acq e0", err, 0);
    idle(1);
    chk("C acq miss", err, 1);

    // LOCK_COUNT=1, WIDTH=8, random frames
    for (int f = 0; f < 6; f++) begin
      r2      = $urandom;
      strobe2 = 1'b1;
      din2    = r2;
      step();
      strobe2 = 1'b0;
      chk($sformatf("D%0d lk", f), lk2, (f >= 1));
      chk($sformatf("D%0d vld", f), vld2, (f >= 1));
      chk($sformatf("D%0d w0", f), dout2, r2[7:0]);
      for (int k = 1; k < 4; k++) begin
        step();
        chk($sformatf("D%0d w%0d", f, k),
            dout2, r2[k*8 +: 8]);
      end
    end

`ifdef FRAME_MUX4_ERRCNT_EN
    for (int i = 0; i < 301; i++) begin
      strobe2 = 1'b1;
      step();
      strobe2 = 1'b0;
      step();
    end
    step();
    step();
    chk("E sat", ecnt2, 8'd255);
    reset2 = 1'b1;
    step();
    chk("E clr", ecnt2, 8'd0);
    reset2 = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
